// File: rtl/fg_pkg.sv
// Shared types for the function-generator measurement datapath.
package fg_pkg;
    localparam int SAMPLE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    // LOW/HIGH encodings double as the 1-bit polarity value.
    typedef enum logic [1:0] {
        CL_LOW  = 2'd0,
        CL_HIGH = 2'd1,
        CL_HOLD = 2'd2
    } cls_t;
endpackage

// File: rtl/square_meter_if.sv
// Sample bus into the square-wave meter and its measurement results.
interface square_meter_if
    import fg_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic                       sample_en;
    logic signed [SAMPLE_W-1:0] sample_in;
    logic                       meas_valid;
    logic                       meas_pol;
    logic [CNT_W-1:0]           half_period;
    logic signed [SAMPLE_W-1:0] high_level;
    logic signed [SAMPLE_W-1:0] low_level;
    logic                       locked;
    logic                       timeout;

    modport master (
        output sample_en, sample_in,
        input  meas_valid, meas_pol, half_period, high_level, low_level, locked, timeout
    );

    modport slave (
        input  sample_en, sample_in,
        output meas_valid, meas_pol, half_period, high_level, low_level, locked, timeout
    );
endinterface

// File: rtl/sq_polarity_slicer.sv
// Combinational high/low/hold classifier with a symmetric hysteresis band.
module sq_polarity_slicer
    import fg_pkg::*;
#(
    parameter logic signed [SAMPLE_W-1:0] HYST = '0
) (
    input  logic signed [SAMPLE_W-1:0] sample,
    output cls_t                       cls
);
    // One extra bit so that -HYST cannot overflow for HYST = -128.
    logic signed [SAMPLE_W:0] s_x;
    logic signed [SAMPLE_W:0] h_x;

    assign s_x = {sample[SAMPLE_W-1], sample};
    assign h_x = {HYST[SAMPLE_W-1], HYST};

    // Above the band is HIGH, below it is LOW, inside it keeps the previous class.
    always_comb begin
        cls = CL_HOLD;
        if (s_x > h_x)
            cls = CL_HIGH;
        else if (s_x < -h_x)
            cls = CL_LOW;
    end
endmodule

// File: rtl/square_meter.sv
// Square-wave meter: half-period length, peak levels, lock and timeout.
module square_meter
    import fg_pkg::*;
#(
    parameter logic signed [SAMPLE_W-1:0] HYST = '0,
    parameter int CNT_W        = 16,
    parameter int TOL          = 0,
    parameter int LOCK_MATCHES = 2
) (
    input  logic         clk,
    input  logic         rst,
    square_meter_if.slave bus
);
    localparam int MW = $clog2(LOCK_MATCHES + 2);
    localparam logic [MW-1:0]  LOCK_M = MW'(LOCK_MATCHES);
    localparam logic [CNT_W:0] TOL_W  = (CNT_W + 1)'(TOL);

    cls_t                       cls;
    state_t                     st_q, st_d;
    logic                       pol_q, pol_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [SAMPLE_W-1:0] peak_q, peak_d;
    logic [1:0][CNT_W-1:0]      last_q, last_d;
    logic [1:0]                 seen_q, seen_d;
    logic [MW-1:0]              mcnt_q, mcnt_d;
    logic                       mv_q, mv_d, mpol_q, mpol_d, lk_q, lk_d, to_q, to_d;
    logic [CNT_W-1:0]           hp_q, hp_d;
    logic signed [SAMPLE_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic                       edge_s, cnt_max;
    logic [CNT_W-1:0]           last_sel, diff;

    sq_polarity_slicer #(.HYST(HYST)) u_slicer (.sample(bus.sample_in), .cls(cls));

    assign edge_s   = (cls == CL_HIGH && !pol_q) || (cls == CL_LOW && pol_q);
    assign cnt_max  = (cnt_q == '1);
    assign last_sel = last_q[pol_q];
    assign diff     = (cnt_q >= last_sel) ? cnt_q - last_sel : last_sel - cnt_q;

    // Next-state and output computation; only accepted samples move anything.
    always_comb begin
        st_d   = st_q;   pol_d  = pol_q;  cnt_d = cnt_q;  peak_d = peak_q;
        last_d = last_q; seen_d = seen_q; mcnt_d = mcnt_q;
        mv_d   = 1'b0;   to_d   = 1'b0;
        mpol_d = mpol_q; hp_d   = hp_q;   hi_d  = hi_q;   lo_d   = lo_q;  lk_d = lk_q;
        if (bus.sample_en) begin
            unique case (st_q)
                ST_IDLE: begin
                    if (cls != CL_HOLD) begin
                        st_d  = ST_SYNC;
                        pol_d = (cls == CL_HIGH);
                        cnt_d = CNT_W'(1);
                    end
                end
                ST_SYNC, ST_MEASURE: begin
                    if (edge_s) begin
                        // The first edge only aligns us; the partial half before it is dropped.
                        if (st_q == ST_MEASURE) begin
                            mv_d   = 1'b1;
                            mpol_d = pol_q;
                            hp_d   = cnt_q;
                            if (pol_q) hi_d = peak_q;
                            else       lo_d = peak_q;
                            if (seen_q[pol_q] && ({1'b0, diff} <= TOL_W))
                                mcnt_d = (mcnt_q >= LOCK_M) ? mcnt_q : mcnt_q + MW'(1);
                            else
                                mcnt_d = '0;
                            last_d[pol_q] = cnt_q;
                            seen_d[pol_q] = 1'b1;
                            lk_d          = (mcnt_d >= LOCK_M);
                        end
                        st_d   = ST_MEASURE;
                        pol_d  = ~pol_q;
                        cnt_d  = CNT_W'(1);
                        peak_d = bus.sample_in;
                    end else if (cnt_max) begin
                        // No edge within the counter range: give up and resynchronise.
                        to_d   = 1'b1;
                        st_d   = ST_IDLE;
                        mcnt_d = '0;
                        lk_d   = 1'b0;
                        seen_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (pol_q && bus.sample_in > peak_q)       peak_d = bus.sample_in;
                        else if (!pol_q && bus.sample_in < peak_q) peak_d = bus.sample_in;
                    end
                end
                default: st_d = ST_IDLE;
            endcase
        end
    end

    // State and registered outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q <= ST_IDLE; pol_q <= 1'b0; cnt_q <= '0; peak_q <= '0;
            last_q <= '0; seen_q <= '0; mcnt_q <= '0;
            mv_q <= 1'b0; mpol_q <= 1'b0; hp_q <= '0; hi_q <= '0; lo_q <= '0;
            lk_q <= 1'b0; to_q <= 1'b0;
        end else begin
            st_q <= st_d; pol_q <= pol_d; cnt_q <= cnt_d; peak_q <= peak_d;
            last_q <= last_d; seen_q <= seen_d; mcnt_q <= mcnt_d;
            mv_q <= mv_d; mpol_q <= mpol_d; hp_q <= hp_d; hi_q <= hi_d; lo_q <= lo_d;
            lk_q <= lk_d; to_q <= to_d;
        end
    end

    assign bus.meas_valid  = mv_q;
    assign bus.meas_pol    = mpol_q;
    assign bus.half_period = hp_q;
    assign bus.high_level  = hi_q;
    assign bus.low_level   = lo_q;
    assign bus.locked      = lk_q;
    assign bus.timeout     = to_q;
endmodule

// File: tb/tb_square_meter.sv
// Scoreboard bench for square_meter: two instances, directed square waves.
module tb_square_meter;
    typedef struct {
        bit is_to;
        bit pol;
        int hp;
        int hi;
        int lo;
        bit lk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always #5 clk = ~clk;

    square_meter_if #(.CNT_W(16)) ifa();
    square_meter_if #(.CNT_W(4))  ifb();

    square_meter #(.HYST(8'sd0), .CNT_W(16), .TOL(0), .LOCK_MATCHES(2))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    square_meter #(.HYST(8'sd10), .CNT_W(4), .TOL(0), .LOCK_MATCHES(2))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp(input string t, input exp_t e, input logic to, input logic mv, input logic pol,
                       input logic signed [31:0] hp, input logic signed [31:0] hi,
                       input logic signed [31:0] lo, input logic lk);
        chk({t, " timeout"}, to, e.is_to);
        chk({t, " meas_valid"}, mv, !e.is_to);
        if (!e.is_to) chk({t, " meas_pol"}, pol, e.pol);
        chk({t, " half_period"}, hp, e.hp);
        chk({t, " high_level"}, hi, e.hi);
        chk({t, " low_level"}, lo, e.lo);
        chk({t, " locked"}, lk, e.lk);
    endtask

    // Monitors: every pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (ifa.meas_valid === 1'b1 || ifa.timeout === 1'b1) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL A unexpected pulse: meas_valid=%0b timeout=%0b hp=%0d, expected no pulse",
                         ifa.meas_valid, ifa.timeout, ifa.half_period);
            end else begin
                ea = qa.pop_front();
                cmp("A", ea, ifa.timeout, ifa.meas_valid, ifa.meas_pol, ifa.half_period,
                    ifa.high_level, ifa.low_level, ifa.locked);
            end
        end
    end

    always @(negedge clk) begin
        if (ifb.meas_valid === 1'b1 || ifb.timeout === 1'b1) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL B unexpected pulse: meas_valid=%0b timeout=%0b hp=%0d, expected no pulse",
                         ifb.meas_valid, ifb.timeout, ifb.half_period);
            end else begin
                eb = qb.pop_front();
                cmp("B", eb, ifb.timeout, ifb.meas_valid, ifb.meas_pol, ifb.half_period,
                    ifb.high_level, ifb.low_level, ifb.locked);
            end
        end
    end

    task automatic push(input bit b, input bit to, input bit pol, input int hp,
                        input int hi, input int lo, input bit lk);
        exp_t e;
        e = '{to, pol, hp, hi, lo, lk};
        if (b) qb.push_back(e);
        else   qa.push_back(e);
    endtask

    // One accepted sample; with gap, an idle cycle carrying a bogus value comes first.
    task automatic drv(input bit b, input bit gap, input logic signed [7:0] v);
        if (gap) begin
            @(negedge clk);
            if (b) begin ifb.sample_en = 1'b0; ifb.sample_in = -8'sd100; end
            else   begin ifa.sample_en = 1'b0; ifa.sample_in = -8'sd100; end
        end
        @(negedge clk);
        if (b) begin ifb.sample_en = 1'b1; ifb.sample_in = v; end
        else   begin ifa.sample_en = 1'b1; ifa.sample_in = v; end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ifa.sample_en = 1'b0;
            ifb.sample_en = 1'b0;
        end
    endtask

    task automatic chk_zero(input string t, input logic mv, input logic pol, input logic [15:0] hp,
                            input logic signed [7:0] hi, input logic signed [7:0] lo,
                            input logic lk, input logic to);
        chk({t, " meas_valid"}, mv, 0);
        chk({t, " meas_pol"}, pol, 0);
        chk({t, " half_period"}, hp, 0);
        chk({t, " high_level"}, hi, 0);
        chk({t, " low_level"}, lo, 0);
        chk({t, " locked"}, lk, 0);
        chk({t, " timeout"}, to, 0);
    endtask

    task automatic do_reset();
        idle(1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    // Instance A square wave starting high; half 0 is the discarded sync half,
    // halves 1..nh-1 are measured, and one extra sample closes the last one.
    task automatic run_sq(input logic signed [7:0] amp, input int nh, input int lens[10], input bit lks[10]);
        int n;
        for (int i = 0; i <= nh; i++) begin
            if (i >= 2)
                push(0, 0, ((i - 1) % 2) == 0, lens[i-1], (i - 1 == 1) ? 0 : int'(amp), -int'(amp), lks[i-2]);
            n = (i == nh) ? 1 : lens[i];
            for (int k = 0; k < n; k++) drv(0, 0, (i % 2 == 0) ? amp : -amp);
        end
        idle(3);
    endtask

    initial begin
        int  lens[10];
        bit  lks[10];
        logic signed [7:0] hv[5];
        logic signed [7:0] lv[5];

        ifa.sample_en = 1'b0; ifa.sample_in = '0;
        ifb.sample_en = 1'b0; ifb.sample_in = '0;
        idle(3);
        chk_zero("A reset", ifa.meas_valid, ifa.meas_pol, 16'(ifa.half_period), ifa.high_level,
                 ifa.low_level, ifa.locked, ifa.timeout);
        chk_zero("B reset", ifb.meas_valid, ifb.meas_pol, 16'(ifb.half_period), ifb.high_level,
                 ifb.low_level, ifb.locked, ifb.timeout);
        rst = 1'b0;

        // Hysteresis (HYST=10): in-band 5 and -5 hold HIGH.
        drv(1, 0, -8'sd50);
        drv(1, 0, 8'sd50); drv(1, 0, 8'sd5); drv(1, 0, -8'sd5); drv(1, 0, 8'sd50);
        push(1, 0, 1, 4, 50, 0, 0);
        drv(1, 0, -8'sd50); drv(1, 0, -8'sd50); drv(1, 0, -8'sd50);
        push(1, 0, 0, 3, 50, -50, 0);
        drv(1, 0, 8'sd50);

        // Timeout (CNT_W=4): high half started at count 1, 15th +20 overflows.
        push(1, 1, 0, 3, 50, -50, 0);
        repeat (15) drv(1, 0, 8'sd20);
        drv(1, 0, 8'sd20);
        repeat (3) drv(1, 0, -8'sd20);
        push(1, 0, 0, 3, 50, -20, 0);
        repeat (2) drv(1, 0, 8'sd20);
        push(1, 0, 1, 2, 20, -20, 0);
        drv(1, 0, -8'sd20);
        // A 15-sample half is the longest reportable one; edge wins over saturation.
        repeat (14) drv(1, 0, -8'sd20);
        push(1, 0, 0, 15, 20, -20, 0);
        drv(1, 0, 8'sd20);
        idle(3);

        // Loopback: +-1, 11 samples per half, lock on the 4th measurement.
        do_reset();
        lens = '{11, 11, 11, 11, 11, 11, 0, 0, 0, 0};
        lks  = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        run_sq(8'sd1, 6, lens, lks);

        // Jitter: a 9 among 8s drops lock and restarts the match count.
        do_reset();
        lens = '{8, 8, 8, 8, 8, 9, 8, 8, 8, 8};
        lks  = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        run_sq(8'sd30, 10, lens, lks);

        // Enable gaps: 5 accepted samples per half, bogus values on idle cycles.
        do_reset();
        hv = '{8'sd3, 8'sd7, 8'sd2, 8'sd9, 8'sd4};
        lv = '{-8'sd2, -8'sd8, -8'sd1, -8'sd5, -8'sd3};
        for (int k = 0; k < 5; k++) drv(0, 1, hv[k]);
        for (int k = 0; k < 5; k++) drv(0, 1, lv[k]);
        push(0, 0, 0, 5, 0, -8, 0);
        for (int k = 0; k < 5; k++) drv(0, 1, hv[k]);
        push(0, 0, 1, 5, 9, -8, 0);
        drv(0, 1, lv[0]);
        drv(0, 1, lv[1]);
        // Reset mid-half while an edge sample is presented: nothing may be emitted.
        @(negedge clk);
        rst = 1'b1; ifa.sample_en = 1'b1; ifa.sample_in = 8'sd50;
        @(negedge clk);
        rst = 1'b0; ifa.sample_en = 1'b0;
        chk_zero("A mid-half reset", ifa.meas_valid, ifa.meas_pol, 16'(ifa.half_period), ifa.high_level,
                 ifa.low_level, ifa.locked, ifa.timeout);
        repeat (3) drv(0, 0, -8'sd5);
        repeat (2) drv(0, 0, 8'sd5);
        idle(4);

        chk("A leftover expectations", qa.size(), 0);
        chk("B leftover expectations", qb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
